// File: rtl/mux_gate_pkg.sv
// mux_gate_pkg: shared constants and types for the mux-built gate array.
//   - Truth-table constants, bit index {a,b} selects the output.
//   - Sweep FSM state encoding (used only when MUX_GATE_SWEEP_EN is defined).
//   - tt_lookup: the per-lane 4:1 mux.
package mux_gate_pkg;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
    return tt[{a, b}];
  endfunction

endpackage

// File: rtl/mux_gate_fifo.sv
// mux_gate_fifo: WIDTH x DEPTH synchronous FIFO, asynchronous active-low reset.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_data     write request and data (ignored when full)
//   pop                 read request (ignored when empty)
//   pop_data            head entry (zero after reset)
//   full, empty         occupancy flags derived from the count register
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mux_gate_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mux_gate_unit.sv
// mux_gate_unit: WIDTH-lane truth-table-programmable 2-input gate array.
// Each lane computes y[i] = tt[{a[i],b[i]}]; results go through a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   cfg_we, cfg_tt         load the 4-bit truth table (resets to TT_NOR)
//   in_valid/in_ready      operand handshake, in_a/in_b operands
//   out_valid/out_ready    result handshake, out_y result (FIFO head)
//   sweep_start            start a 4-step truth-table sweep   (MUX_GATE_SWEEP_EN)
//   sweep_done             one-cycle pulse when sweep ends     (MUX_GATE_SWEEP_EN)
// Build option: define MUX_GATE_SWEEP_EN to include the sweep engine; without it
// the sweep ports are absent and in_ready = !full.
module mux_gate_unit
  import mux_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MUX_GATE_SWEEP_EN
  input  logic             sweep_start,
  output logic             sweep_done,
`endif
  output logic [WIDTH-1:0] out_y
);

  logic [3:0]       tt_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= TT_NOR;
    end else if (cfg_we) begin
      tt_q <= cfg_tt;
    end
  end

`ifdef MUX_GATE_SWEEP_EN
  sweep_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic         sweep_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sweep_push = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (!fifo_full) begin
          sweep_push = 1'b1;
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        sweep_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = !fifo_full && (state_q == IDLE);

  // sweep_start takes priority over an external operand in the same IDLE cycle,
  // even though in_ready is still high that cycle.
  always_comb begin
    if (sweep_push) begin
      op_a = {WIDTH{idx_q[1]}};
      op_b = {WIDTH{idx_q[0]}};
    end else begin
      op_a = in_a;
      op_b = in_b;
    end
  end
  assign push = sweep_push || (in_valid && in_ready && !sweep_start);
`else
  assign in_ready = !fifo_full;
  assign op_a     = in_a;
  assign op_b     = in_b;
  assign push     = in_valid && in_ready;
`endif

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      y[i] = tt_lookup(tt_q, op_a[i], op_b[i]);
    end
  end

  mux_gate_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (y),
    .pop       (out_ready),
    .pop_data  (out_y),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_mux_gate_unit.sv
module tb_mux_gate_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_tt;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
`ifdef MUX_GATE_SWEEP_EN
  logic       sweep_start;
  logic       sweep_done;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux_gate_unit #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_tt      (cfg_tt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef MUX_GATE_SWEEP_EN
    .sweep_start (sweep_start),
    .sweep_done  (sweep_done),
`endif
    .out_y       (out_y)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_tt    = 4'h0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
`ifdef MUX_GATE_SWEEP_EN
    sweep_start = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one operand pair for a single edge (FIFO assumed not full), then idle.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_tt    = 4'h0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
`ifdef MUX_GATE_SWEEP_EN
    sweep_start = 1'b0;
`endif
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_y !== 8'h00) $display("FAIL reset_out_y got %h exp 00", out_y); else n_pass++;
`ifdef MUX_GATE_SWEEP_EN
    n_checks++; if (sweep_done !== 1'b0) $display("FAIL reset_sweep_done got %b exp 0", sweep_done); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nor_default();
    push_pair(8'h0F, 8'h33);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL nor_valid got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_y !== 8'hC0) $display("FAIL nor_y got %h exp c0", out_y); else n_pass++;
    pop_one();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL nor_drained got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_program();
    cfg_we = 1'b1; cfg_tt = 4'b0110;
    @(negedge clk);
    cfg_we = 1'b0;
    push_pair(8'hF0, 8'h3C);
    n_checks++; if (out_y !== 8'hCC) $display("FAIL xor_y got %h exp cc", out_y); else n_pass++;
    pop_one();
    cfg_we = 1'b1; cfg_tt = 4'b1000;
    @(negedge clk);
    cfg_we = 1'b0;
    push_pair(8'hF0, 8'h3C);
    n_checks++; if (out_y !== 8'h30) $display("FAIL and_y got %h exp 30", out_y); else n_pass++;
    pop_one();
  endtask

  task automatic test_cfg_same_cycle();
    do_reset();
    cfg_we = 1'b1; cfg_tt = 4'b1110;
    push_pair(8'h00, 8'h00);
    cfg_we = 1'b0;
    n_checks++; if (out_y !== 8'hFF) $display("FAIL cfg_old_tt got %h exp ff", out_y); else n_pass++;
    pop_one();
    push_pair(8'h00, 8'h00);
    n_checks++; if (out_y !== 8'h00) $display("FAIL cfg_new_tt got %h exp 00", out_y); else n_pass++;
    pop_one();
  endtask

  // tt is OR here, so each result equals the a operand.
  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h00;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %b exp 1", in_ready); else n_pass++;
    in_a = 8'h02;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %b exp 0", in_ready); else n_pass++;
    in_a = 8'h04;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_held got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (out_y !== 8'h01) $display("FAIL bp_head0 got %h exp 01", out_y); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_y !== 8'h02) $display("FAIL bp_head1 got %h exp 02", out_y); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_y !== 8'h04 || out_valid !== 1'b1) $display("FAIL bp_head2 got %h/%b exp 04/1", out_y, out_valid); else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", out_valid); else n_pass++;
  endtask

`ifdef MUX_GATE_SWEEP_EN
  // Assumes tt=NOR, FIFO empty, FSM in IDLE.
  task automatic run_full_sweep(input string tag);
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'h00; exp_seq[3] = 8'h00;
    out_ready   = 1'b1;
    sweep_start = 1'b1;
    in_valid    = 1'b1; in_a = 8'hAA; in_b = 8'h55;
    @(negedge clk);
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL %s_ready_sweep got %b exp 0", tag, in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== exp_seq[i] || in_ready !== 1'b0)
        $display("FAIL %s_step%0d got v=%b y=%h r=%b exp v=1 y=%h r=0", tag, i, out_valid, out_y, in_ready, exp_seq[i]);
      else n_pass++;
    end
    n_checks++; if (sweep_done !== 1'b1) $display("FAIL %s_done got %b exp 1", tag, sweep_done); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (sweep_done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_after got d=%b v=%b r=%b exp d=0 v=0 r=1", tag, sweep_done, out_valid, in_ready);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    do_reset();
    run_full_sweep("sweep");
  endtask

  task automatic test_sweep_reset();
    int seen_done;
    do_reset();
    out_ready   = 1'b0;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL swrst_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL swrst_ready got %b exp 1", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sweep_done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done != 0) $display("FAIL swrst_no_done got %0d pulses exp 0", seen_done); else n_pass++;
    run_full_sweep("resweep");
  endtask
`endif

  initial begin
    test_reset();
    test_nor_default();
    test_program();
    test_cfg_same_cycle();
    test_back_to_back();
`ifdef MUX_GATE_SWEEP_EN
    test_sweep();
    test_sweep_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
